// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS main control FSM.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    ALUWB   = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'd0;
  localparam logic [5:0] OP_J     = 6'd2;
  localparam logic [5:0] OP_BEQ   = 6'd4;
  localparam logic [5:0] OP_ADDI  = 6'd8;
  localparam logic [5:0] OP_LW    = 6'd35;
  localparam logic [5:0] OP_SW    = 6'd43;

  localparam logic [1:0] ALUOP_ADD  = 2'b00;
  localparam logic [1:0] ALUOP_SUB  = 2'b01;
  localparam logic [1:0] ALUOP_FUNC = 2'b10;

  localparam logic [1:0] SRCB_RT      = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctrl_t;

  // States whose exit to FETCH completes (retires) an instruction.
  function automatic logic retires(state_e s);
    return s inside {MEMWB, MEMWR, ALUWB, BRANCH, JUMP, ADDIWB};
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Enable counter with async active-low clear; wraps silently.
module retire_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (en_i) count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS datapath: sequences each instruction,
// waits on MemReady for memory states and counts retired instructions.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Opcode,
  input  logic             MemReady,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             MemtoReg,
  output logic             RegDst,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             IllegalOp,
  output logic [CNT_W-1:0] InstrCount
);

  state_e state_q, state_d;
  ctrl_t  ctrl_c;
  ctrl_t  ctrl_gated;
  logic   retire_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= FETCH;
    else        state_q <= state_d;
  end

  // Next state and Moore output decode; FETCH strobes are qualified by MemReady.
  always_comb begin
    state_d = state_q;
    ctrl_c  = '0;
    unique case (state_q)
      FETCH: begin
        ctrl_c.mem_read  = 1'b1;
        ctrl_c.alu_src_b = SRCB_FOUR;
        ctrl_c.pc_write  = MemReady;
        ctrl_c.ir_write  = MemReady;
        if (MemReady) state_d = DECODE;
      end
      DECODE: begin
        ctrl_c.alu_src_b = SRCB_IMM_SH2;
        case (Opcode)
          OP_RTYPE:     state_d = EXEC;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDIEX;
          default:      state_d = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        ctrl_c.mem_read = 1'b1;
        ctrl_c.i_or_d   = 1'b1;
        if (MemReady) state_d = MEMWB;
      end
      MEMWB: begin
        ctrl_c.reg_write  = 1'b1;
        ctrl_c.mem_to_reg = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        ctrl_c.mem_write = 1'b1;
        ctrl_c.i_or_d    = 1'b1;
        if (MemReady) state_d = FETCH;
      end
      EXEC: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_RT;
        ctrl_c.alu_op    = ALUOP_FUNC;
        state_d = ALUWB;
      end
      ALUWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.reg_dst   = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        ctrl_c.alu_src_a     = 1'b1;
        ctrl_c.alu_op        = ALUOP_SUB;
        ctrl_c.pc_write_cond = 1'b1;
        ctrl_c.pc_source     = PCSRC_ALUOUT;
        state_d = FETCH;
      end
      JUMP: begin
        ctrl_c.pc_write  = 1'b1;
        ctrl_c.pc_source = PCSRC_JUMP;
        state_d = FETCH;
      end
      ADDIEX: begin
        ctrl_c.alu_src_a = 1'b1;
        ctrl_c.alu_src_b = SRCB_IMM;
        ctrl_c.alu_op    = ALUOP_ADD;
        state_d = ADDIWB;
      end
      ADDIWB: begin
        ctrl_c.reg_write = 1'b1;
        ctrl_c.pc_source = PCSRC_ALU;
        state_d = FETCH;
      end
      ILLEGAL: begin
        ctrl_c.illegal_op = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset silences every control line immediately, abandoning any pending request.
  assign ctrl_gated = rst_n ? ctrl_c : '0;

  assign PCWrite     = ctrl_gated.pc_write;
  assign PCWriteCond = ctrl_gated.pc_write_cond;
  assign IorD        = ctrl_gated.i_or_d;
  assign MemRead     = ctrl_gated.mem_read;
  assign MemWrite    = ctrl_gated.mem_write;
  assign IRWrite     = ctrl_gated.ir_write;
  assign MemtoReg    = ctrl_gated.mem_to_reg;
  assign RegDst      = ctrl_gated.reg_dst;
  assign RegWrite    = ctrl_gated.reg_write;
  assign ALUSrcA     = ctrl_gated.alu_src_a;
  assign ALUSrcB     = ctrl_gated.alu_src_b;
  assign ALUOp       = ctrl_gated.alu_op;
  assign PCSource    = ctrl_gated.pc_source;
  assign IllegalOp   = ctrl_gated.illegal_op;

  assign retire_c = retires(state_q) && (state_d == FETCH);

  retire_counter #(
    .CNT_W (CNT_W)
  ) u_retire_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (retire_c),
    .count_o (InstrCount)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: expected per-cycle controls are queued
// as instructions are scheduled, then driven and compared cycle by cycle.
module tb_multicycle_control;

  localparam int B_FETCH   = 0;
  localparam int B_DECODE  = 1;
  localparam int B_MEMADR  = 2;
  localparam int B_MEMRD   = 3;
  localparam int B_MEMWB   = 4;
  localparam int B_MEMWR   = 5;
  localparam int B_EXEC    = 6;
  localparam int B_ALUWB   = 7;
  localparam int B_BRANCH  = 8;
  localparam int B_JUMP    = 9;
  localparam int B_ADDIEX  = 10;
  localparam int B_ADDIWB  = 11;
  localparam int B_ILLEGAL = 12;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  Opcode;
  logic        MemReady;

  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegDst, RegWrite, ALUSrcA, IllegalOp;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [31:0] InstrCount;

  logic        PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4;
  logic        MemtoReg4, RegDst4, RegWrite4, ALUSrcA4, IllegalOp4;
  logic [1:0]  ALUSrcB4, ALUOp4, PCSource4;
  logic [3:0]  InstrCount4;

  logic [16:0] act, act4;

  typedef struct {
    logic [5:0]  op;
    logic        mr;
    int          code;
    logic [16:0] ctl;
    logic [31:0] cnt;
  } cyc_t;

  cyc_t        sb_q[$];
  logic [31:0] exp_cnt;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  multicycle_control #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .IllegalOp(IllegalOp), .InstrCount(InstrCount)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
    .PCWrite(PCWrite4), .PCWriteCond(PCWriteCond4), .IorD(IorD4), .MemRead(MemRead4),
    .MemWrite(MemWrite4), .IRWrite(IRWrite4), .MemtoReg(MemtoReg4), .RegDst(RegDst4),
    .RegWrite(RegWrite4), .ALUSrcA(ALUSrcA4), .ALUSrcB(ALUSrcB4), .ALUOp(ALUOp4),
    .PCSource(PCSource4), .IllegalOp(IllegalOp4), .InstrCount(InstrCount4)
  );

  assign act  = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                 RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, IllegalOp};
  assign act4 = {PCWrite4, PCWriteCond4, IorD4, MemRead4, MemWrite4, IRWrite4, MemtoReg4,
                 RegDst4, RegWrite4, ALUSrcA4, ALUSrcB4, ALUOp4, PCSource4, IllegalOp4};

  // Reference control table, packed in the same order as act.
  function automatic logic [16:0] exp_ctl(int code, logic mr);
    logic pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0; irw = 1'b0;
    m2r = 1'b0; rdst = 1'b0; rw = 1'b0; sa = 1'b0; ill = 1'b0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (code)
      B_FETCH:   begin mrd = 1'b1; sb = 2'b01; pcw = mr; irw = mr; end
      B_DECODE:  sb = 2'b11;
      B_MEMADR:  begin sa = 1'b1; sb = 2'b10; end
      B_MEMRD:   begin mrd = 1'b1; iord = 1'b1; end
      B_MEMWB:   begin rw = 1'b1; m2r = 1'b1; end
      B_MEMWR:   begin mwr = 1'b1; iord = 1'b1; end
      B_EXEC:    begin sa = 1'b1; ao = 2'b10; end
      B_ALUWB:   begin rw = 1'b1; rdst = 1'b1; end
      B_BRANCH:  begin sa = 1'b1; ao = 2'b01; pcwc = 1'b1; ps = 2'b01; end
      B_JUMP:    begin pcw = 1'b1; ps = 2'b10; end
      B_ADDIEX:  begin sa = 1'b1; sb = 2'b10; end
      B_ADDIWB:  rw = 1'b1;
      B_ILLEGAL: ill = 1'b1;
      default:   ;
    endcase
    return {pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, ill};
  endfunction

  task automatic push_cyc(input logic [5:0] op, input logic mr, input int code);
    cyc_t c;
    c.op   = op;
    c.mr   = mr;
    c.code = code;
    c.ctl  = exp_ctl(code, mr);
    c.cnt  = exp_cnt;
    sb_q.push_back(c);
  endtask

  // MemReady is random in states that must ignore it.
  task automatic push_instr(input logic [5:0] op, input int fetch_waits, input int mem_waits);
    for (int i = 0; i < fetch_waits; i++) push_cyc(op, 1'b0, B_FETCH);
    push_cyc(op, 1'b1, B_FETCH);
    push_cyc(op, 1'($urandom_range(0, 1)), B_DECODE);
    case (op)
      6'd0: begin
        push_cyc(op, 1'($urandom_range(0, 1)), B_EXEC);
        push_cyc(op, 1'($urandom_range(0, 1)), B_ALUWB);
      end
      6'd35: begin
        push_cyc(op, 1'($urandom_range(0, 1)), B_MEMADR);
        for (int i = 0; i < mem_waits; i++) push_cyc(op, 1'b0, B_MEMRD);
        push_cyc(op, 1'b1, B_MEMRD);
        push_cyc(op, 1'($urandom_range(0, 1)), B_MEMWB);
      end
      6'd43: begin
        push_cyc(op, 1'($urandom_range(0, 1)), B_MEMADR);
        for (int i = 0; i < mem_waits; i++) push_cyc(op, 1'b0, B_MEMWR);
        push_cyc(op, 1'b1, B_MEMWR);
      end
      6'd4: push_cyc(op, 1'($urandom_range(0, 1)), B_BRANCH);
      6'd2: push_cyc(op, 1'($urandom_range(0, 1)), B_JUMP);
      6'd8: begin
        push_cyc(op, 1'($urandom_range(0, 1)), B_ADDIEX);
        push_cyc(op, 1'($urandom_range(0, 1)), B_ADDIWB);
      end
      default: push_cyc(op, 1'($urandom_range(0, 1)), B_ILLEGAL);
    endcase
    if (op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd2, 6'd8}) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Entered right at a falling edge; drives one cycle per entry and compares.
  task automatic run_queue();
    cyc_t c;
    while (sb_q.size() > 0) begin
      c = sb_q.pop_front();
      Opcode   = c.op;
      MemReady = c.mr;
      #1;
      checks += 4;
      if (act !== c.ctl) begin
        errors++;
        $display("FAIL ctl st=%0d op=%0d mr=%0b got %b exp %b", c.code, c.op, c.mr, act, c.ctl);
      end
      if (InstrCount !== c.cnt) begin
        errors++;
        $display("FAIL count st=%0d got %0d exp %0d", c.code, InstrCount, c.cnt);
      end
      if (act4 !== c.ctl) begin
        errors++;
        $display("FAIL ctl4 st=%0d got %b exp %b", c.code, act4, c.ctl);
      end
      if (InstrCount4 !== c.cnt[3:0]) begin
        errors++;
        $display("FAIL count4 st=%0d got %0d exp %0d", c.code, InstrCount4, c.cnt[3:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks += 3;
    if ({act, act4} !== 34'd0) begin
      errors++;
      $display("FAIL %s ctl got %b/%b exp all zero", name, act, act4);
    end
    if (InstrCount !== 32'd0) begin
      errors++;
      $display("FAIL %s count got %0d exp 0", name, InstrCount);
    end
    if (InstrCount4 !== 4'd0) begin
      errors++;
      $display("FAIL %s count4 got %0d exp 0", name, InstrCount4);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    MemReady = 1'b1;
    Opcode   = 6'd0;
    @(negedge clk);
    #1;
    check_all_zero("reset_hold");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 32'd0;
  endtask

  task automatic test_rtype();
    push_instr(6'd0, 0, 0);
    push_instr(6'd0, 2, 0);
    run_queue();
  endtask

  task automatic test_lw();
    push_instr(6'd35, 0, 3);
    push_instr(6'd35, 1, 0);
    run_queue();
  endtask

  task automatic test_beq();
    push_instr(6'd4, 0, 0);
    run_queue();
  endtask

  task automatic test_illegal();
    push_instr(6'd63, 0, 0);
    push_instr(6'd17, 1, 0);
    push_instr(6'd0, 0, 0);
    run_queue();
  endtask

  task automatic test_back_to_back();
    push_instr(6'd43, 0, 0);
    push_instr(6'd43, 1, 2);
    push_instr(6'd8, 0, 0);
    push_instr(6'd2, 3, 0);
    push_instr(6'd35, 0, 0);
    push_instr(6'd4, 0, 0);
    run_queue();
  endtask

  task automatic test_reset_mid();
    push_cyc(6'd35, 1'b1, B_FETCH);
    push_cyc(6'd35, 1'b0, B_DECODE);
    push_cyc(6'd35, 1'b1, B_MEMADR);
    push_cyc(6'd35, 1'b0, B_MEMRD);
    run_queue();
    Opcode   = 6'd35;
    MemReady = 1'b0;
    #1;
    checks++;
    if (act !== exp_ctl(B_MEMRD, 1'b0)) begin
      errors++;
      $display("FAIL memrd_wait ctl got %b exp %b", act, exp_ctl(B_MEMRD, 1'b0));
    end
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("reset_mid");
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 32'd0;
    push_instr(6'd0, 0, 0);
    run_queue();
  endtask

  task automatic test_wrap();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 32'd0;
    for (int i = 0; i < 17; i++) push_instr(6'd2, (i == 5) ? 1 : 0, 0);
    run_queue();
    Opcode   = 6'd0;
    MemReady = 1'b0;
    #1;
    checks += 2;
    if (InstrCount4 !== 4'd1) begin
      errors++;
      $display("FAIL wrap count4 got %0d exp 1", InstrCount4);
    end
    if (InstrCount !== 32'd17) begin
      errors++;
      $display("FAIL wrap count got %0d exp 17", InstrCount);
    end
  endtask

  initial begin
    exp_cnt = 32'd0;
    test_reset();
    test_rtype();
    test_lw();
    test_beq();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
